// File: rtl/debounce_sync.sv
// debounce_sync: multi-channel input conditioner.
// Each raw bit passes through a two-flop synchronizer, then a per-channel
// stability counter that only lets a new level through after it has been
// seen for STABLE_CYCLES consecutive cycles. One-cycle rise/fall pulses are
// registered alongside the clean level.
// Optional feature macro: DEBOUNCE_SYNC_TOGGLE_EN adds a 'toggle' output
// that flips once per rising edge of the debounced level.
module debounce_sync #(
    parameter int WIDTH         = 1,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`ifdef DEBOUNCE_SYNC_TOGGLE_EN
    ,
    output logic [WIDTH-1:0] toggle
`endif
);

    // Counter width is derived from the stability threshold only.
    localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] out_q,  out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Two-flop synchronizer; only s2_q is allowed to reach the filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw_in;
            s2_q <= s1_q;
        end
    end

    // Per-channel filter: count consecutive disagreements, commit on the last one.
    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                out_d[i]  = s2_q[i];
                cnt_d[i]  = '0;
                rise_d[i] = s2_q[i];
                fall_d[i] = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Filter state and registered edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef DEBOUNCE_SYNC_TOGGLE_EN
    logic [WIDTH-1:0] toggle_q;

    // Latched level that flips the cycle after each rise pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_q <= '0;
        end else begin
            toggle_q <= toggle_q ^ rise_q;
        end
    end

    assign toggle = toggle_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync (WIDTH=4, STABLE_CYCLES=4). A window-based
// reference model decides when each channel's level flips: the level
// changes on an edge when the last STABLE_CYCLES synchronized samples all
// disagree with it. Directed scenarios are followed by a random phase.
module tb_debounce_sync;

    localparam int W = 4;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] out, rise, fall;
`ifdef DEBOUNCE_SYNC_TOGGLE_EN
    logic [W-1:0] toggle;
`endif

    debounce_sync #(.WIDTH(W), .STABLE_CYCLES(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .raw_in (raw_in),
        .out    (out),
        .rise   (rise),
        .fall   (fall)
`ifdef DEBOUNCE_SYNC_TOGGLE_EN
        ,
        .toggle (toggle)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [W-1:0] rawq [$];   // raw samples still travelling through the synchronizer
    logic [W-1:0] hist [$];   // most recent filter-input samples, at most N
    logic [W-1:0] m_out  = '0;
    logic [W-1:0] m_rise = '0;
    logic [W-1:0] m_fall = '0;
    logic [W-1:0] m_tog  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [W-1:0] r, input logic rs);
        logic [W-1:0] fin;
        logic         flip;
        if (rs) begin
            m_out  = '0;
            m_rise = '0;
            m_fall = '0;
            m_tog  = '0;
            rawq.delete();
            rawq.push_back('0);
            rawq.push_back('0);
            hist.delete();
        end else begin
            fin = rawq.pop_front();
            rawq.push_back(r);
            hist.push_back(fin);
            if (hist.size() > N) void'(hist.pop_front());
            m_tog = m_tog ^ m_rise;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                flip = (hist.size() == N);
                for (int k = 0; k < hist.size(); k++)
                    if (hist[k][i] == m_out[i]) flip = 1'b0;
                if (flip) begin
                    m_out[i]  = ~m_out[i];
                    m_rise[i] = m_out[i];
                    m_fall[i] = ~m_out[i];
                end
            end
        end
    endtask

    task automatic step(input logic [W-1:0] r, input logic rs);
        @(negedge clk);
        raw_in = r;
        rst    = rs;
        @(posedge clk);
        model_edge(r, rs);
        #1;
        check("out",  32'(out),  32'(m_out));
        check("rise", 32'(rise), 32'(m_rise));
        check("fall", 32'(fall), 32'(m_fall));
        check("rise_and_fall", 32'(rise & fall), 32'd0);
`ifdef DEBOUNCE_SYNC_TOGGLE_EN
        check("toggle", 32'(toggle), 32'(m_tog));
`endif
    endtask

    // Hard stop if something wedges the clock-driven sequence.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int nrise;
        int seen;
        logic [W-1:0] r;
        logic         rs;

        // Reset held with all inputs high: everything stays at zero.
        for (int k = 0; k < 3; k++) begin
            step('1, 1'b1);
            check("reset_out", 32'(out), 32'd0);
        end
        // Release with inputs still high: first free edge is capture edge 0.
        lat = -1; nrise = 0;
        for (int k = 0; k < 10; k++) begin
            step('1, 1'b0);
            if (out[0] && lat < 0) lat = k;
            if (rise[0]) nrise++;
        end
        check("post_reset_latency", 32'(lat), 32'd5);
        check("post_reset_rise_count", 32'(nrise), 32'd1);

        // Clean release on all channels, then a clean press/release on channel 0.
        for (int k = 0; k < 10; k++) step('0, 1'b0);
        lat = -1; nrise = 0;
        for (int k = 0; k < 10; k++) begin
            step(4'b0001, 1'b0);
            if (out[0] && lat < 0) lat = k;
            if (rise[0]) nrise++;
            check("press_no_fall", 32'(fall), 32'd0);
        end
        check("press_latency", 32'(lat), 32'd5);
        check("press_rise_count", 32'(nrise), 32'd1);
        lat = -1; seen = 0;
        for (int k = 0; k < 10; k++) begin
            step('0, 1'b0);
            if (!out[0] && lat < 0) lat = k;
            if (fall[0]) seen++;
        end
        check("release_latency", 32'(lat), 32'd5);
        check("release_fall_count", 32'(seen), 32'd1);

        // Bounce 1,0,1,1,0 then held high: exactly one rise.
        nrise = 0;
        step(4'b0001, 1'b0); step('0, 1'b0); step(4'b0001, 1'b0);
        step(4'b0001, 1'b0); step('0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            step(4'b0001, 1'b0);
            if (rise[0]) nrise++;
        end
        check("bounce_rise_count", 32'(nrise), 32'd1);
        check("bounce_final_out", 32'(out), 32'd1);
        for (int k = 0; k < 10; k++) step('0, 1'b0);

        // Glitch of 3 cycles never reaches the output.
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            step(4'b0001, 1'b0);
            if (out != 0 || rise != 0 || fall != 0) seen++;
        end
        for (int k = 0; k < 10; k++) begin
            step('0, 1'b0);
            if (out != 0 || rise != 0 || fall != 0) seen++;
        end
        check("glitch_activity", 32'(seen), 32'd0);

        // Multi-channel: two channels rise together, then one falls alone.
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step(4'b0101, 1'b0);
            if (out != 0 && seen == 0) begin
                seen = 1;
                check("multi_out",  32'(out),  32'h5);
                check("multi_rise", 32'(rise), 32'h5);
                check("multi_fall", 32'(fall), 32'h0);
            end
        end
        check("multi_rise_seen", 32'(seen), 32'd1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step(4'b0100, 1'b0);
            if (fall != 0) begin
                seen++;
                check("multi_fall_only", 32'(fall), 32'h1);
                check("multi_fall_norise", 32'(rise), 32'h0);
            end
        end
        check("multi_fall_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 8; k++) step('0, 1'b0);

        // Reset mid-count discards progress; a full latency follows.
        for (int k = 0; k < 4; k++) step(4'b0001, 1'b0);
        step(4'b0001, 1'b1);
        check("midcount_reset_out", 32'(out), 32'd0);
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            step(4'b0001, 1'b0);
            if (out[0] && lat < 0) lat = k;
        end
        check("midcount_latency", 32'(lat), 32'd5);
        for (int k = 0; k < 10; k++) step('0, 1'b0);

`ifdef DEBOUNCE_SYNC_TOGGLE_EN
        // Two presses flip the latched level up and back down.
        for (int k = 0; k < 8; k++) step(4'b0001, 1'b0);
        check("toggle_after_first", 32'(toggle[0]), 32'd1);
        for (int k = 0; k < 8; k++) step('0, 1'b0);
        for (int k = 0; k < 8; k++) step(4'b0001, 1'b0);
        for (int k = 0; k < 8; k++) step('0, 1'b0);
        check("toggle_after_second", 32'(toggle[0]), 32'd0);
`endif

        // Random phase: per-channel holds with occasional flips and resets.
        r = '0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 4) == 0) r[i] = ~r[i];
            rs = ($urandom_range(0, 79) == 0);
            step(r, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
